// File: rtl/gcd_controller.sv
// gcd_controller
//   Moore FSM that sequences the 5-bit subtractive GCD datapath. It drives the
//   input-mux select code and the A/B register load enables, and runs a
//   start/ready/done handshake with the host.
//
//   Ports
//     clk, rst_n           clock (rising edge), asynchronous active-low reset
//     start / ready        host request (sampled only while ready=1) / idle flag
//     a_gt_b, a_lt_b       comparator flags from the registered A and B
//     a_zero, b_zero       zero flags from the registered A and B
//     sel                  mux select {sel1,sel2,sel3}
//     ld_a, ld_b           A / B register load enables
//     done                 one-cycle completion pulse
//     res_sel              0 = result in A, 1 = result in B (valid with done)
//     iter_count           subtraction steps of the current/last run
//     err                  timeout abort flag
//
//   Optional feature: define GCD_TIMEOUT_EN to abort after MAX_ITER
//   subtraction steps (err=1). Without it, err is tied 0 and runs are unbounded.
//
//   All outputs are registered. Each transition loads the output values that
//   belong to the state being entered, so every output is a clean flop.

module gcd_controller #(
    parameter int CNT_W    = 5,
    parameter int MAX_ITER = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    input  logic             a_zero,
    input  logic             b_zero,
    output logic [2:0]       sel,
    output logic             ld_a,
    output logic             ld_b,
    output logic             done,
    output logic             res_sel,
    output logic [CNT_W-1:0] iter_count,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CMP  = 3'd2,
        SUBA = 3'd3,
        SUBB = 3'd4,
        DONE = 3'd5
    } state_t;

    // Select codes: only these two are ever driven. 3'b001 and 3'b010 would
    // update just one register input path.
    localparam logic [2:0] SEL_EXT = 3'b100;
    localparam logic [2:0] SEL_SUB = 3'b011;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;

    // True when the compare step would start another subtraction but the
    // step budget is already used up.
    logic timeout_hit;

`ifdef GCD_TIMEOUT_EN
    logic err_q;
    assign timeout_hit = (iter_count == CNT_W'(MAX_ITER));
    assign err         = err_q;
`else
    logic unused_max_iter;
    assign timeout_hit     = 1'b0;
    assign err             = 1'b0;
    assign unused_max_iter = (MAX_ITER != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready      <= 1'b1;
            sel        <= SEL_SUB;
            ld_a       <= 1'b0;
            ld_b       <= 1'b0;
            done       <= 1'b0;
            res_sel    <= 1'b0;
            iter_count <= '0;
`ifdef GCD_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            // Default output values; each branch overrides the values for the
            // state it enters.
            ready <= 1'b0;
            sel   <= SEL_SUB;
            ld_a  <= 1'b0;
            ld_b  <= 1'b0;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        sel   <= SEL_EXT;
                        ld_a  <= 1'b1;
                        ld_b  <= 1'b1;
                    end else begin
                        ready <= 1'b1;
                    end
                end

                LOAD: begin
                    state      <= CMP;
                    iter_count <= '0;
                    res_sel    <= 1'b0;
`ifdef GCD_TIMEOUT_EN
                    err_q      <= 1'b0;
`endif
                end

                CMP: begin
                    if (a_zero) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        res_sel <= 1'b1;
                    end else if (b_zero || (!a_gt_b && !a_lt_b)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        res_sel <= 1'b0;
                    end else if (timeout_hit) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        res_sel <= 1'b0;
`ifdef GCD_TIMEOUT_EN
                        err_q   <= 1'b1;
`endif
                    end else if (a_gt_b) begin
                        // a_gt_b wins if both flags are (illegally) high.
                        state <= SUBA;
                        ld_a  <= 1'b1;
                    end else begin
                        state <= SUBB;
                        ld_b  <= 1'b1;
                    end
                end

                SUBA, SUBB: begin
                    state <= CMP;
                    if (iter_count != CNT_MAX)
                        iter_count <= iter_count + 1'b1;
                end

                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller
//   Closed-loop bench: a small A/B register + subtractor model sits beside the
//   controller and produces the comparator/zero flags. Directed runs with
//   hand-computed latencies and results.

module tb_gcd_controller;

`ifdef GCD_TIMEOUT_EN
    localparam int TB_MAX_ITER = 4;
`else
    localparam int TB_MAX_ITER = 31;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ready;
    logic       a_gt_b, a_lt_b, a_zero, b_zero;
    logic [2:0] sel;
    logic       ld_a, ld_b, done, res_sel, err;
    logic [4:0] iter_count;

    // datapath model
    logic [4:0] in_a = '0, in_b = '0;
    logic [4:0] ra = '0, rb = '0;
    logic       force_gt = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ld_a) ra <= (sel == 3'b100) ? in_a : ra - rb;
        if (ld_b) rb <= (sel == 3'b100) ? in_b : rb - ra;
    end

    assign a_gt_b = (ra > rb) | force_gt;
    assign a_lt_b = (ra < rb);
    assign a_zero = (ra == 5'd0);
    assign b_zero = (rb == 5'd0);

    gcd_controller #(.CNT_W(5), .MAX_ITER(TB_MAX_ITER)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ready      (ready),
        .a_gt_b     (a_gt_b),
        .a_lt_b     (a_lt_b),
        .a_zero     (a_zero),
        .b_zero     (b_zero),
        .sel        (sel),
        .ld_a       (ld_a),
        .ld_b       (ld_b),
        .done       (done),
        .res_sel    (res_sel),
        .iter_count (iter_count),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start, count cycles after the sampling edge until done, then check.
    task automatic run(input string tag, input logic [4:0] a, input logic [4:0] b,
                       input int exp_cyc, input logic exp_rs, input int exp_it,
                       input logic [4:0] exp_res, input logic exp_err);
        int cyc;
        logic got;
        @(negedge clk);
        in_a = a; in_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        got = done;
        while (!got && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            got = done;
        end
        chk({tag, ".cyc"}, cyc, exp_cyc);
        chk({tag, ".res_sel"}, res_sel, exp_rs);
        chk({tag, ".iter"}, iter_count, exp_it);
        chk({tag, ".result"}, res_sel ? rb : ra, exp_res);
        chk({tag, ".err"}, err, exp_err);
        @(posedge clk); #1;
        chk({tag, ".done_1cyc"}, done, 0);
        chk({tag, ".ready"}, ready, 1);
    endtask

    initial begin
        int loads, cyc, dones;

        // reset with start held high
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", ready, 1);
        chk("rst.sel", sel, 3'b011);
        chk("rst.ld", {ld_a, ld_b}, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.iter", iter_count, 0);
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle.ready", ready, 1);

        run("g12_8",  5'd12, 5'd8,  7, 1'b0, 2, 5'd4, 1'b0);
        run("g5_15",  5'd5,  5'd15, 7, 1'b0, 2, 5'd5, 1'b0);
`ifndef GCD_TIMEOUT_EN
        run("g31_1",  5'd31, 5'd1, 63, 1'b0, 30, 5'd1, 1'b0);
`endif
        run("z0_9",   5'd0,  5'd9,  3, 1'b1, 0, 5'd9, 1'b0);
        run("z7_0",   5'd7,  5'd0,  3, 1'b0, 0, 5'd7, 1'b0);
        run("eq6_6",  5'd6,  5'd6,  3, 1'b0, 0, 5'd6, 1'b0);

        // start held through a run: exactly one LOAD, then a new LOAD right after
        @(negedge clk);
        in_a = 5'd12; in_b = 5'd8; start = 1'b1;
        loads = 0; cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (sel == 3'b100 && ld_a) loads++;
        end while (!done && cyc < 200);
        chk("hold.cyc", cyc, 7);
        chk("hold.loads", loads, 1);
        @(posedge clk); #1;
        chk("hold.idle", ready, 1);
        @(posedge clk); #1;
        chk("hold.reload", {sel, ld_a, ld_b}, {3'b100, 2'b11});
        start = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < 200);
        chk("hold.cyc2", cyc, 6);
        @(posedge clk); #1;

        // reset during SUBB aborts without done
        @(negedge clk);
        in_a = 5'd5; in_b = 5'd15; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort.in_subb", {ld_b, ld_a}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.ready", ready, 1);
        chk("abort.ld_b", ld_b, 0);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort.no_done", dones, 0);
        chk("abort.idle", ready, 1);

`ifdef GCD_TIMEOUT_EN
        force_gt = 1'b1;
        run("tmo", 5'd20, 5'd1, 11, 1'b0, 4, 5'd16, 1'b1);
        force_gt = 1'b0;
        run("tmo_clr", 5'd12, 5'd8, 7, 1'b0, 2, 5'd4, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
